// File: rtl/mem_access_pkg.sv
// Shared FSM encoding, timer width and bus-error read data for the memory access unit.
// Used by mem_access_unit and wait_timer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;
  localparam int          TIMER_W      = 8;

  function automatic logic [TIMER_W-1:0] expire_count(input int timeout);
    return TIMER_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts REQ cycles without an acknowledge and flags the last permitted cycle.
module wait_timer
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  // High during the cycle in which a missing ack ends the access.
  assign expire = (count == expire_count(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// Bridges CPU MemRead/MemWrite to a single-outstanding request/ack memory bus with timeout.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses skip the bus and pulse align_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        align_err
);

  state_t state;
  state_t next_state;

  logic accept;
  logic misaligned;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;
  logic ack_hit;
  logic timeout_hit;

  assign accept = (state == ST_IDLE) && (cpu_read || cpu_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = accept && (cpu_addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign misaligned       = 1'b0;
  assign unused_addr_bits = ^cpu_addr[1:0];
`endif

  assign ack_hit      = (state == ST_REQ) && mem_ack;
  assign timeout_hit  = (state == ST_REQ) && !mem_ack && timer_expire;
  assign timer_clear  = (state != ST_REQ);
  assign timer_enable = (state == ST_REQ) && !mem_ack;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (misaligned) begin
          next_state = ST_DONE;
        end else if (accept) begin
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_hit || timeout_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // The stall rises in the same cycle a request appears so the controller never advances past it.
  always_comb begin
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    unique case (state)
      ST_IDLE: cpu_stall = accept;
      ST_REQ: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
      end
      ST_DONE: cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      mem_we    <= cpu_write;
      mem_addr  <= cpu_addr[31:2];
      mem_wdata <= cpu_wdata;
    end
  end

  // Read data only moves on a completed or timed-out read; error flags live for the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      bus_err   <= timeout_hit;
      align_err <= misaligned;
      if (ack_hit && !mem_we) begin
        cpu_rdata <= mem_rdata;
      end else if (timeout_hit && !mem_we) begin
        cpu_rdata <= BUS_ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, corner sequences and random traffic vs. a transaction model.
// Honours MEM_ALIGN_CHECK_EN when computing expectations.
module tb_mem_access_unit;

  localparam int TO_MAIN = 8;
  localparam int TO_SHORT = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        bus_err;
  logic        align_err;

  logic [31:0] t4_cpu_rdata;
  logic        t4_cpu_stall;
  logic        t4_mem_req;
  logic        t4_mem_we;
  logic [29:0] t4_mem_addr;
  logic [31:0] t4_mem_wdata;
  logic        t4_bus_err;
  logic        t4_align_err;

  int checks = 0;
  int passed = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .align_err(align_err)
  );

  mem_access_unit #(.TIMEOUT(TO_SHORT)) dut_t4 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(t4_cpu_rdata),
    .cpu_stall(t4_cpu_stall), .mem_req(t4_mem_req), .mem_we(t4_mem_we), .mem_addr(t4_mem_addr),
    .mem_wdata(t4_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(t4_bus_err), .align_err(t4_align_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic [29:0] exp_maddr;
    int          exp_req;
    int          exp_stall;
    logic        exp_bus;
    logic        exp_align;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One complete CPU access; delay = REQ cycles without ack before the ack cycle.
  task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic [31:0] rdata,
                                input logic [29:0] exp_maddr, input int exp_req, input int exp_stall,
                                input logic exp_bus, input logic exp_align, input logic [31:0] exp_rdata);
    int req_cnt = 0;
    int stall_cnt = 0;
    int bus_cnt = 0;
    int align_cnt = 0;
    int cyc = 0;
    logic done = 1'b0;
    logic hold_ok = 1'b1;
    logic [31:0] rd_done = 32'h0;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      mem_rdata = $urandom;
      mem_ack = 1'b0;
      if (cpu_stall) stall_cnt++;
      if (bus_err) bus_cnt++;
      if (align_err) align_cnt++;
      if (cyc > 0 && cpu_stall && cpu_rdata !== model_rdata) hold_ok = 1'b0;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== exp_maddr || mem_we !== wr || (wr && mem_wdata !== wdata)) hold_ok = 1'b0;
        if (req_cnt == delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (cyc > 0 && !cpu_stall) begin
        done = 1'b1;
        rd_done = cpu_rdata;
      end
      @(posedge clk); #1;
      cpu_read = 1'b0; cpu_write = 1'b0; mem_ack = 1'b0;
      cyc++;
    end
    check_output({tag, "_finished"}, 32'(done), 32'd1);
    check_output({tag, "_req_cycles"}, req_cnt, exp_req);
    check_output({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    check_output({tag, "_bus_err_pulses"}, bus_cnt, exp_bus ? 1 : 0);
    check_output({tag, "_align_err_pulses"}, align_cnt, exp_align ? 1 : 0);
    check_output({tag, "_cpu_rdata"}, rd_done, exp_rdata);
    check_output({tag, "_bus_fields_held"}, 32'(hold_ok), 32'd1);
    @(negedge clk);
    check_output({tag, "_idle_after"}, {28'h0, bus_err, align_err, mem_req, cpu_stall}, 32'h0);
    @(posedge clk); #1;
    model_rdata = exp_rdata;
  endtask

  initial begin
    int cnt, bus_cnt, st_cnt;
    logic [31:0] rd_at;
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; model_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("reset_cpu_rdata", cpu_rdata, 32'h0);
    check_output("reset_bus_outputs", {mem_req, mem_we, cpu_stall, bus_err, align_err}, 32'h0);
    check_output("reset_mem_addr", {2'b00, mem_addr}, 32'h0);
    check_output("reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h2008_0005, 30'h4, 1, 2, 1'b0, 1'b0, 32'h2008_0005};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4, 32'h1234_5678, 30'h40, 5, 6, 1'b0, 1'b0, 32'h2008_0005};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 7, 32'hCAFE_F00D, 30'h80, 8, 9, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 8, 32'h1111_2222, 30'hC0, 8, 9, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0304, 32'h0F0F_0F0F, 8, 32'h0, 30'hC1, 8, 9, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_55AA, 1, 32'h0BAD_BEEF, 30'h2, 2, 3, 1'b0, 1'b0, 32'hFFFF_FFFF};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h1357_9BDF, 30'h0, 0, 1, 1'b0, 1'b1, 32'hFFFF_FFFF};
`else
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h1357_9BDF, 30'h0, 1, 2, 1'b0, 1'b0, 32'h1357_9BDF};
`endif
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 2, 32'hA5A5_A5A5, 30'h3FFF_FFFF, 3, 4, 1'b0, 1'b0, 32'hA5A5_A5A5};

    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     vecs[i].delay, vecs[i].rdata, vecs[i].exp_maddr, vecs[i].exp_req,
                     vecs[i].exp_stall, vecs[i].exp_bus, vecs[i].exp_align, vecs[i].exp_rdata);
    end

    // Acknowledge strobes while idle must not disturb anything.
    mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check_output("ack_outside_req_rdata", cpu_rdata, model_rdata);
    check_output("ack_outside_req_idle", {mem_req, cpu_stall}, 32'h0);
    @(posedge clk); #1;

    // A read held through DONE is ignored there and re-accepted in the following IDLE.
    cpu_read = 1'b1; cpu_addr = 32'h0000_0020;
    @(negedge clk);
    check_output("held_req_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check_output("done_ignores_req", {mem_req, cpu_stall}, 32'h0);
    check_output("done_rdata", cpu_rdata, 32'h0102_0304);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("reaccept_after_done", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1 cpu_read = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0506_0708;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check_output("reaccept_rdata", cpu_rdata, 32'h0506_0708);
    @(posedge clk); #1;
    model_rdata = 32'h0506_0708;

    // Read that never completes against the TIMEOUT=4 instance.
    cnt = 0; bus_cnt = 0; st_cnt = 0; rd_at = 32'h0;
    cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (t4_mem_req) cnt++;
      if (t4_cpu_stall) st_cnt++;
      if (t4_bus_err) begin
        bus_cnt++;
        rd_at = t4_cpu_rdata;
      end
      @(posedge clk); #1 cpu_read = 1'b0;
    end
    check_output("t4_req_cycles", cnt, 4);
    check_output("t4_stall_cycles", st_cnt, 5);
    check_output("t4_bus_err_pulses", bus_cnt, 1);
    check_output("t4_timeout_rdata", rd_at, 32'hFFFF_FFFF);
    check_output("t4_fields", {t4_align_err, t4_mem_we, t4_mem_addr}, 32'h10);
    model_rdata = 32'hFFFF_FFFF;

    for (int n = 0; n < 40; n++) begin
      logic rd, wr, mis, acked, eb, ea;
      logic [31:0] addr, wdata, rdata, erd;
      int delay, er, es;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      wdata = $urandom;
      rdata = $urandom;
      delay = $urandom_range(0, 10);
      mis = ALIGN_EN && (addr % 4 != 0);
      acked = (delay < TO_MAIN);
      if (mis) begin
        er = 0; es = 1; eb = 1'b0; ea = 1'b1; erd = model_rdata;
      end else begin
        er = acked ? delay + 1 : TO_MAIN;
        es = er + 1;
        eb = !acked;
        ea = 1'b0;
        erd = wr ? model_rdata : (acked ? rdata : 32'hFFFF_FFFF);
      end
      apply_stimulus($sformatf("rnd%0d", n), rd, wr, addr, wdata, delay, rdata,
                     30'(addr / 4), er, es, eb, ea, erd);
    end

    // Reset during the second REQ cycle of a read+write access aborts it.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'h1122_3344;
    @(posedge clk); #1 cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    check_output("rw_conflict_is_write", {mem_req, mem_we}, 32'h3);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_output("reset_pending_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_output("reset_abort_idle", {mem_req, cpu_stall, bus_err}, 32'h0);
    check_output("reset_abort_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("reset_abort_stays_idle", {mem_req, cpu_stall}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
